// File: rtl/issue_scoreboard.sv
// Issue controller: 32-entry destination scoreboard, in-flight cap and drain/fence sequencer.
// Optional stall-cycle performance counter enabled by defining ISSUE_SB_PERF_EN.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int WB_BYPASS    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_rd_wr_en_i,
  input  logic        ex_ready_i,
  output logic        id_ready_o,
  output logic        issue_o,
  input  logic        retire_i,
  input  logic        retire_rd_wr_en_i,
  input  logic [4:0]  retire_rd_addr_i,
  input  logic        flush_i,
  input  logic        drain_i,
  output logic        drain_done_o,
  output logic [31:0] pending_o,
  output logic [3:0]  inflight_o,
  output logic        err_o
`ifdef ISSUE_SB_PERF_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic {RUN, DRAIN} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

  state_t      state;
  logic [31:0] pending;
  logic [3:0]  inflight;
  logic        err;
  logic        drain_done;

  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] visible;
  logic        hazard;
  logic [3:0]  inflight_next;
  logic        underflow;

  assign pending_o    = pending;
  assign inflight_o   = inflight;
  assign err_o        = err;
  assign drain_done_o = drain_done;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    clr_mask = '0;
    if (retire_i && retire_rd_wr_en_i) clr_mask[retire_rd_addr_i] = 1'b1;
  end

  // The register file is write-through, so a same-cycle writeback already satisfies the reader.
  assign visible = (WB_BYPASS != 0) ? (pending & ~clr_mask) : pending;

  assign hazard = (id_rs1_used_i && (id_rs1_addr_i != 5'd0) && visible[id_rs1_addr_i])
               || (id_rs2_used_i && (id_rs2_addr_i != 5'd0) && visible[id_rs2_addr_i])
               || (id_rd_wr_en_i && (id_rd_addr_i  != 5'd0) && visible[id_rd_addr_i]);

  assign id_ready_o = ex_ready_i && !hazard && (inflight < MAX_CNT)
                   && (state == RUN) && !flush_i && !rst_i;
  assign issue_o    = id_valid_i && id_ready_o;

  always_comb begin
    set_mask = '0;
    if (issue_o && id_rd_wr_en_i && (id_rd_addr_i != 5'd0)) set_mask[id_rd_addr_i] = 1'b1;
  end

  always_comb begin
    inflight_next = inflight;
    underflow     = 1'b0;
    if (flush_i) begin
      inflight_next = '0;
    end else if (issue_o && !retire_i) begin
      inflight_next = inflight + 4'd1;
    end else if (retire_i && !issue_o) begin
      if (inflight == 4'd0) underflow = 1'b1;
      else                  inflight_next = inflight - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RUN;
      pending    <= '0;
      inflight   <= '0;
      err        <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      // Clear first, then set: a same-register set/clear collision leaves the bit set.
      pending    <= flush_i ? '0 : ((pending & ~clr_mask) | set_mask);
      inflight   <= inflight_next;
      drain_done <= 1'b0;
      if (underflow) err <= 1'b1;
      case (state)
        RUN: begin
          if (drain_i) begin
            if (inflight_next == 4'd0) drain_done <= 1'b1;
            else                       state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight_next == 4'd0) begin
            state      <= RUN;
            drain_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef ISSUE_SB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (id_valid_i && !id_ready_o && (state == RUN) && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed vector table, corner sequences,
// and randomized traffic against a behavioural scoreboard model.
module tb_issue_scoreboard;

  localparam int MAXI = 4;
  localparam int BYP  = 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        id_valid_i = 1'b0;
  logic [4:0]  id_rs1_addr_i = '0, id_rs2_addr_i = '0, id_rd_addr_i = '0;
  logic        id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0, id_rd_wr_en_i = 1'b0;
  logic        ex_ready_i = 1'b1;
  logic        id_ready_o, issue_o;
  logic        retire_i = 1'b0, retire_rd_wr_en_i = 1'b0;
  logic [4:0]  retire_rd_addr_i = '0;
  logic        flush_i = 1'b0, drain_i = 1'b0;
  logic        drain_done_o;
  logic [31:0] pending_o;
  logic [3:0]  inflight_o;
  logic        err_o;
`ifdef ISSUE_SB_PERF_EN
  logic [31:0] stall_cnt;
`endif

  issue_scoreboard #(.MAX_INFLIGHT(MAXI), .WB_BYPASS(BYP)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rd_addr_i(id_rd_addr_i), .id_rd_wr_en_i(id_rd_wr_en_i), .ex_ready_i(ex_ready_i),
    .id_ready_o(id_ready_o), .issue_o(issue_o),
    .retire_i(retire_i), .retire_rd_wr_en_i(retire_rd_wr_en_i), .retire_rd_addr_i(retire_rd_addr_i),
    .flush_i(flush_i), .drain_i(drain_i), .drain_done_o(drain_done_o),
    .pending_o(pending_o), .inflight_o(inflight_o), .err_o(err_o)
`ifdef ISSUE_SB_PERF_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       valid;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, rd_wr;
    logic       ex_ready;
    logic       retire, retire_wr;
    logic [4:0] retire_rd;
    logic       flush, drain;
  } in_t;

  typedef struct {
    in_t         in;
    logic        ready;
    logic        issue;
    logic [31:0] pend;
    logic [3:0]  infl;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic got_ready, got_issue;

  // Behavioural model: set of busy registers, an integer count, and a drain flag.
  bit mpend[32];
  int mcount;
  bit mdrain, mdone, merr;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t r;
    r = '{default: '0};
    r.ex_ready = 1'b1;
    return r;
  endfunction

  function automatic in_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                             logic [4:0] rd, logic w, logic ret, logic retw, logic [4:0] retrd);
    in_t r;
    r = idle();
    r.valid = v; r.rs1 = rs1; r.rs1_used = u1; r.rs2 = rs2; r.rs2_used = u2;
    r.rd = rd; r.rd_wr = w; r.retire = ret; r.retire_wr = retw; r.retire_rd = retrd;
    return r;
  endfunction

  function automatic vec_t mkv(in_t s, logic r, logic i, logic [31:0] p, logic [3:0] n);
    vec_t v;
    v.in = s; v.ready = r; v.issue = i; v.pend = p; v.infl = n;
    return v;
  endfunction

  function automatic bit m_busy(logic [4:0] a, in_t s);
    if (a == 5'd0) return 1'b0;
    if (BYP != 0 && s.retire && s.retire_wr && s.retire_rd == a) return 1'b0;
    return mpend[a];
  endfunction

  function automatic logic [31:0] m_packed();
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[i] = mpend[i];
    return p;
  endfunction

  task automatic model_reset();
    foreach (mpend[i]) mpend[i] = 1'b0;
    mcount = 0; mdrain = 1'b0; mdone = 1'b0; merr = 1'b0;
  endtask

  task automatic model_advance(in_t s, bit iss);
    if (s.flush) begin
      foreach (mpend[i]) mpend[i] = 1'b0;
      mcount = 0;
    end else begin
      if (s.retire && s.retire_wr) mpend[s.retire_rd] = 1'b0;
      if (iss && s.rd_wr && s.rd != 5'd0) mpend[s.rd] = 1'b1;
      if (iss && !s.retire) mcount++;
      else if (s.retire && !iss) begin
        if (mcount == 0) merr = 1'b1;
        else mcount--;
      end
    end
    mdone = 1'b0;
    if (!mdrain) begin
      if (s.drain) begin
        if (mcount == 0) mdone = 1'b1;
        else mdrain = 1'b1;
      end
    end else if (mcount == 0) begin
      mdrain = 1'b0;
      mdone  = 1'b1;
    end
  endtask

  task automatic drive(in_t s);
    rst_i = 1'b0;
    id_valid_i = s.valid; id_rs1_addr_i = s.rs1; id_rs2_addr_i = s.rs2; id_rd_addr_i = s.rd;
    id_rs1_used_i = s.rs1_used; id_rs2_used_i = s.rs2_used; id_rd_wr_en_i = s.rd_wr;
    ex_ready_i = s.ex_ready; retire_i = s.retire; retire_rd_wr_en_i = s.retire_wr;
    retire_rd_addr_i = s.retire_rd; flush_i = s.flush; drain_i = s.drain;
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered state after the edge.
  task automatic step(in_t s);
    bit hz, exp_ready, exp_issue;
    @(negedge clk_i);
    drive(s);
    #1;
    hz = (s.rs1_used && m_busy(s.rs1, s)) || (s.rs2_used && m_busy(s.rs2, s))
      || (s.rd_wr && m_busy(s.rd, s));
    exp_ready = s.ex_ready && !hz && (mcount < MAXI) && !mdrain && !s.flush;
    exp_issue = s.valid && exp_ready;
    got_ready = id_ready_o;
    got_issue = issue_o;
    check("model_id_ready", id_ready_o, exp_ready);
    check("model_issue", issue_o, exp_issue);
    @(posedge clk_i);
    model_advance(s, exp_issue);
    #1;
    check("model_pending", pending_o, m_packed());
    check("model_inflight", inflight_o, mcount);
    check("model_err", err_o, merr);
    check("model_drain_done", drain_done_o, mdone);
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      drive(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0));
      rst_i = 1'b1;
      #1;
      check("reset_id_ready", id_ready_o, 0);
      check("reset_issue", issue_o, 0);
      @(posedge clk_i);
      #1;
      model_reset();
    end
    check("reset_pending", pending_o, 0);
    check("reset_inflight", inflight_o, 0);
    check("reset_err", err_o, 0);
    check("reset_drain_done", drain_done_o, 0);
  endtask

  vec_t tbl[13];
  in_t  s, rt, vi;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset(2);

    // RAW with bypass, x0 / unused source, WAW with same-cycle set-wins.
    tbl[0]  = mkv(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0), 1, 1, 32'h20, 1);
    tbl[1]  = mkv(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0), 0, 0, 32'h20, 1);
    tbl[2]  = mkv(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0), 0, 0, 32'h20, 1);
    tbl[3]  = mkv(mk(1, 5, 1, 0, 0, 6, 1, 1, 1, 5), 1, 1, 32'h40, 1);
    tbl[4]  = mkv(mk(1, 0, 1, 6, 0, 0, 1, 0, 0, 0), 1, 1, 32'h40, 2);
    tbl[5]  = mkv(mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 0), 0, 0, 32'h40, 2);
    tbl[6]  = mkv(mk(1, 0, 0, 6, 1, 0, 0, 1, 1, 6), 1, 1, 32'h00, 2);
    tbl[7]  = mkv(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, 0, 32'h00, 1);
    tbl[8]  = mkv(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, 0, 32'h00, 0);
    tbl[9]  = mkv(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0), 1, 1, 32'h08, 1);
    tbl[10] = mkv(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0), 0, 0, 32'h08, 1);
    tbl[11] = mkv(mk(1, 0, 0, 0, 0, 3, 1, 1, 1, 3), 1, 1, 32'h08, 1);
    tbl[12] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3), 1, 0, 32'h00, 0);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].in);
      check($sformatf("tbl%0d_ready", i), got_ready, tbl[i].ready);
      check($sformatf("tbl%0d_issue", i), got_issue, tbl[i].issue);
      check($sformatf("tbl%0d_pending", i), pending_o, tbl[i].pend);
      check($sformatf("tbl%0d_inflight", i), inflight_o, tbl[i].infl);
    end

    vi = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rt = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Inflight cap and simultaneous issue+retire at 3.
    repeat (4) step(vi);
    check("cap_inflight4", inflight_o, 4);
    step(vi);
    check("cap_ready_low", got_ready, 0);
    step(rt);
    check("cap_inflight3", inflight_o, 3);
    s = vi; s.retire = 1'b1;
    step(s);
    check("cap_issue_retire", got_issue, 1);
    check("cap_hold3", inflight_o, 3);
    repeat (3) step(rt);
    check("cap_empty", inflight_o, 0);

    // Flush with a valid instruction presented.
    step(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0));
    check("flush_pre_pending", pending_o, 32'hA0);
    check("flush_pre_inflight", inflight_o, 2);
    s = mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); s.flush = 1'b1;
    step(s);
    check("flush_issue", got_issue, 0);
    check("flush_pending", pending_o, 0);
    check("flush_inflight", inflight_o, 0);

    // Drain with two outstanding, then drain at zero.
    step(vi); step(vi);
    s = idle(); s.drain = 1'b1;
    step(s);
    step(vi);
    check("drain_ready_low", got_ready, 0);
    s = rt; s.valid = 1'b1;
    step(s);
    check("drain_ready_low2", got_ready, 0);
    check("drain_not_done", drain_done_o, 0);
    step(rt);
    check("drain_done", drain_done_o, 1);
    check("drain_empty", inflight_o, 0);
    step(vi);
    check("drain_resume", got_issue, 1);
    check("drain_done_pulse", drain_done_o, 0);
    step(rt);
    s = idle(); s.drain = 1'b1;
    step(s);
    check("drain_zero_done", drain_done_o, 1);
    step(idle());
    check("drain_zero_pulse", drain_done_o, 0);

    // Underflow is sticky; reset in the middle of a drain.
    step(rt);
    check("underflow_err", err_o, 1);
    check("underflow_hold", inflight_o, 0);
    step(idle());
    check("underflow_sticky", err_o, 1);
    step(vi);
    s = idle(); s.drain = 1'b1;
    step(s);
    step(vi);
    check("mid_drain_ready_low", got_ready, 0);
    do_reset(1);
    step(vi);
    check("post_reset_run", got_issue, 1);
    step(rt);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      s.valid     = ($urandom_range(0, 3) != 0);
      s.rs1       = 5'($urandom_range(0, 7));
      s.rs2       = 5'($urandom_range(0, 7));
      s.rd        = 5'($urandom_range(0, 7));
      s.rs1_used  = 1'($urandom_range(0, 1));
      s.rs2_used  = 1'($urandom_range(0, 1));
      s.rd_wr     = 1'($urandom_range(0, 1));
      s.ex_ready  = ($urandom_range(0, 7) != 0);
      s.retire    = ($urandom_range(0, 2) == 0);
      s.retire_wr = 1'($urandom_range(0, 1));
      s.retire_rd = 5'($urandom_range(0, 7));
      s.flush     = ($urandom_range(0, 40) == 0);
      s.drain     = ($urandom_range(0, 20) == 0);
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
